// File: rtl/fetcher.sv
// Warp fetch scheduler: tracks IDLE/READY/WAITING per warp, admits new warps,
// picks one READY warp round-robin for the instruction cache and re-arms it
// once the decoder reports the instruction it fetched.
module fetcher #(
    parameter int  PcWidth   = 32,
    parameter int  NumWarps  = 8,
    parameter int  WarpWidth = 32,
    localparam int WidWidth  = (NumWarps > 1) ? $clog2(NumWarps) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_valid_i,
    output logic                 start_ready_o,
    input  logic [PcWidth-1:0]   start_pc_i,
    input  logic [WarpWidth-1:0] start_act_mask_i,
    input  logic                 ic_ready_i,
    output logic                 fe_valid_o,
    output logic [PcWidth-1:0]   fe_pc_o,
    output logic [WarpWidth-1:0] fe_act_mask_o,
    output logic [WidWidth-1:0]  fe_warp_id_o,
    input  logic                 dec_decoded_i,
    input  logic                 dec_stop_warp_i,
    input  logic [WidWidth-1:0]  dec_decoded_warp_id_i,
    input  logic [PcWidth-1:0]   dec_decoded_next_pc_i,
    output logic [NumWarps-1:0]  warp_active_o,
    output logic                 all_idle_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READY   = 2'd1,
        WAITING = 2'd2
    } warp_state_e;

    warp_state_e          state_q [NumWarps];
    warp_state_e          state_d [NumWarps];
    logic [PcWidth-1:0]   pc_q    [NumWarps];
    logic [PcWidth-1:0]   pc_d    [NumWarps];
    logic [WarpWidth-1:0] mask_q  [NumWarps];
    logic [WarpWidth-1:0] mask_d  [NumWarps];

    // A selection offered to the cache but not yet accepted stays pinned here.
    logic                 hold_valid_q, hold_valid_d;
    logic [WidWidth-1:0]  hold_id_q, hold_id_d;
    logic [WidWidth-1:0]  last_grant_q, last_grant_d;

    logic                 any_idle;
    logic [WidWidth-1:0]  start_idx;
    logic                 rr_found;
    logic [WidWidth-1:0]  rr_idx;
    logic [WidWidth-1:0]  sel_id;
    logic                 dec_hit;

    // Per-warp activity flags and the lowest-index IDLE warp for admission.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned, which would infer a latch.
        any_idle      = 1'b0;
        start_idx     = '0;
        warp_active_o = '0;
        // Walk downward so the last hit, i.e. the lowest index, wins.
        for (int i = NumWarps - 1; i >= 0; i--) begin
            if (state_q[i] == IDLE) begin
                any_idle  = 1'b1;
                start_idx = WidWidth'(i);
            end else begin
                warp_active_o[i] = 1'b1;
            end
        end
    end

    // Round-robin search over READY warps starting just after the last grant.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 1; k <= NumWarps; k++) begin
            if (!rr_found && state_q[(int'(last_grant_q) + k) % NumWarps] == READY) begin
                rr_found = 1'b1;
                rr_idx   = WidWidth'((int'(last_grant_q) + k) % NumWarps);
            end
        end
    end

    // A held selection always beats a fresh search, so a newly READY warp
    // cannot preempt a request the cache has not yet taken.
    assign sel_id        = hold_valid_q ? hold_id_q : rr_idx;
    assign fe_valid_o    = hold_valid_q | rr_found;
    assign fe_warp_id_o  = sel_id;
    assign fe_pc_o       = pc_q[sel_id];
    assign fe_act_mask_o = mask_q[sel_id];
    assign start_ready_o = any_idle;
    assign all_idle_o    = ~|warp_active_o;

    // Decode results only count for a warp that actually has a fetch in flight.
    assign dec_hit = dec_decoded_i
                  && (int'(dec_decoded_warp_id_i) < NumWarps)
                  && (state_q[dec_decoded_warp_id_i] == WAITING);

    // Next-state: fetch handshake, decode completion and warp admission.
    // The three events touch distinct warps (READY, WAITING, IDLE) so they
    // can all apply in the same cycle without conflict.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mask_d       = mask_q;
        hold_valid_d = hold_valid_q;
        hold_id_d    = hold_id_q;
        last_grant_d = last_grant_q;

        if (fe_valid_o && ic_ready_i) begin
            state_d[sel_id] = WAITING;
            last_grant_d    = sel_id;
            hold_valid_d    = 1'b0;
        end else if (fe_valid_o) begin
            hold_valid_d = 1'b1;
            hold_id_d    = sel_id;
        end

        if (dec_hit) begin
            if (dec_stop_warp_i) begin
                state_d[dec_decoded_warp_id_i] = IDLE;
            end else begin
                state_d[dec_decoded_warp_id_i] = READY;
                pc_d[dec_decoded_warp_id_i]    = dec_decoded_next_pc_i;
            end
        end

        // A warp stopping this cycle is still WAITING here, so it is not a
        // candidate for this cycle's start.
        if (start_valid_i && any_idle) begin
            state_d[start_idx] = READY;
            pc_d[start_idx]    = start_pc_i;
            mask_d[start_idx]  = start_act_mask_i;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the PC and mask arrays are reset on purpose: the request
            // payload is visible on the ports right after reset and must read 0.
            for (int i = 0; i < NumWarps; i++) begin
                state_q[i] <= IDLE;
                pc_q[i]    <= '0;
                mask_q[i]  <= '0;
            end
            hold_valid_q <= 1'b0;
            hold_id_q    <= '0;
            last_grant_q <= WidWidth'(NumWarps - 1);
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q      <= state_d;
            pc_q         <= pc_d;
            mask_q       <= mask_d;
            hold_valid_q <= hold_valid_d;
            hold_id_q    <= hold_id_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifndef SYNTHESIS
    // Flag decode events for warps that have no instruction in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_i && dec_decoded_i) begin
            assert (dec_hit)
            else $warning("fetcher: decode for warp %0d ignored, warp not WAITING",
                          dec_decoded_warp_id_i);
        end
    end
`endif

endmodule
